// File: rtl/oracle_req_bridge_pkg.sv
// Shared types and defaults for the oracle request bridge.
package oracle_req_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD0000;

  // Saturating increment for the 16-bit event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/oracle_req_bridge_timeout_ctr.sv
// Clear/enable counter with a terminal-count flag at MAX_CYC-1.
module oracle_timeout_ctr #(
  parameter int unsigned MAX_CYC = 256,
  localparam int unsigned W      = $clog2(MAX_CYC)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(MAX_CYC - 1);

  logic [W-1:0] cnt;

  // Count enabled cycles; clear has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/oracle_req_bridge.sv
// Bridges the CPU's level-held logic request to a tagged valid/ready solver
// request and returns a one-cycle ack, with a bounded timeout.
module oracle_req_bridge
  import oracle_req_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned TAG_W       = 4,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             logic_req,
  input  logic [31:0]      logic_addr,
  output logic             logic_ack,
  output logic [31:0]      logic_data,
  output logic             eng_req_valid,
  input  logic             eng_req_ready,
  output logic [31:0]      eng_req_addr,
  output logic [TAG_W-1:0] eng_req_tag,
  input  logic             eng_rsp_valid,
  input  logic [TAG_W-1:0] eng_rsp_tag,
  input  logic [31:0]      eng_rsp_data,
  input  logic             eng_rsp_err,
  output logic             timeout_err,
  output logic             busy,
  output logic [31:0]      req_count,
  output logic [15:0]      timeout_count,
  output logic [15:0]      stale_count
);

  state_t state, state_nxt;
  logic   tc;
  logic   rsp_match;
  logic   to_fire;
  logic   timeout_err_q;

  oracle_timeout_ctr #(.MAX_CYC(TIMEOUT_CYC)) u_timeout_ctr (
    .clk (clk),
    .rst (rst),
    .clr ((state == IDLE) || (state == ACK)),
    .en  ((state == ISSUE) || (state == WAIT)),
    .tc  (tc)
  );

  // A matching response in the terminal-count cycle takes precedence over the timeout.
  assign rsp_match = eng_rsp_valid && (state == WAIT) && (eng_rsp_tag == eng_req_tag);
  assign to_fire   = tc && ((state == ISSUE) || ((state == WAIT) && !rsp_match));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (logic_req) state_nxt = ISSUE;
      ISSUE: if (tc) state_nxt = ACK;
             else if (eng_req_ready) state_nxt = WAIT;
      WAIT:  if (rsp_match || tc) state_nxt = ACK;
      ACK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: address capture, answer word, tag and event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_req_addr  <= '0;
      eng_req_tag   <= '0;
      logic_data    <= '0;
      timeout_err_q <= 1'b0;
      req_count     <= '0;
      timeout_count <= '0;
      stale_count   <= '0;
    end else begin
      if ((state == IDLE) && logic_req) eng_req_addr <= logic_addr;
      if (rsp_match)    logic_data <= eng_rsp_err ? ERR_DATA : eng_rsp_data;
      else if (to_fire) logic_data <= ERR_DATA;
      timeout_err_q <= to_fire;
      if (to_fire) timeout_count <= sat_inc16(timeout_count);
      if (eng_rsp_valid && !rsp_match) stale_count <= sat_inc16(stale_count);
      if (state == ACK) begin
        req_count   <= req_count + 32'd1;
        eng_req_tag <= eng_req_tag + 1'b1;
      end
    end
  end

  assign eng_req_valid = (state == ISSUE);
  assign logic_ack     = (state == ACK);
  assign timeout_err   = timeout_err_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_oracle_req_bridge.sv
// Scoreboard bench for oracle_req_bridge: directed scenarios plus randomized requests.
module tb_oracle_req_bridge;

  localparam int unsigned TO  = 16;
  localparam logic [31:0] ERR = 32'hDEAD0000;

  logic        clk, rst;
  logic        logic_req;
  logic [31:0] logic_addr;
  logic        logic_ack;
  logic [31:0] logic_data;
  logic        eng_req_valid, eng_req_ready;
  logic [31:0] eng_req_addr;
  logic [3:0]  eng_req_tag;
  logic        eng_rsp_valid;
  logic [3:0]  eng_rsp_tag;
  logic [31:0] eng_rsp_data;
  logic        eng_rsp_err;
  logic        timeout_err, busy;
  logic [31:0] req_count;
  logic [15:0] timeout_count, stale_count;

  oracle_req_bridge #(.TIMEOUT_CYC(TO), .TAG_W(4), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .logic_req(logic_req), .logic_addr(logic_addr),
    .logic_ack(logic_ack), .logic_data(logic_data),
    .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready),
    .eng_req_addr(eng_req_addr), .eng_req_tag(eng_req_tag),
    .eng_rsp_valid(eng_rsp_valid), .eng_rsp_tag(eng_rsp_tag),
    .eng_rsp_data(eng_rsp_data), .eng_rsp_err(eng_rsp_err),
    .timeout_err(timeout_err), .busy(busy),
    .req_count(req_count), .timeout_count(timeout_count), .stale_count(stale_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        to;
  } exp_t;

  exp_t        expq[$];
  int unsigned vectors, miscompares;

  // Reference model state: what the bridge should report after each transaction.
  logic [3:0]  m_tag;
  int unsigned m_req, m_to, m_stale;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack pops the oldest expected answer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (logic_ack) begin
          if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_ack: got ack with data %h, expected no ack", logic_data);
          end else begin
            e = expq.pop_front();
            chk("ack_data", logic_data, e.data);
            chk("ack_timeout_err", {31'b0, timeout_err}, {31'b0, e.to});
          end
        end else if (timeout_err) begin
          chk("timeout_err_without_ack", {31'b0, timeout_err}, 32'd0);
        end
      end
    end
  end

  task automatic clear_inputs();
    logic_req     = 1'b0;
    eng_req_ready = 1'b0;
    eng_rsp_valid = 1'b0;
    eng_rsp_tag   = '0;
    eng_rsp_data  = '0;
    eng_rsp_err   = 1'b0;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_req_count"}, req_count, m_req);
    chk({tag, "_timeout_count"}, {16'b0, timeout_count}, m_to);
    chk({tag, "_stale_count"}, {16'b0, stale_count}, m_stale);
    chk({tag, "_tag"}, {28'b0, eng_req_tag}, {28'b0, m_tag});
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  // One CPU request. Cycle k counts from the first cycle the request is visible
  // to the solver; ready rises at k=h, the correct response is sent at k=r, and
  // an optional wrong-tag response at k=s. The bridge gives up after TO cycles.
  task automatic do_req(input logic [31:0] addr, input int h, input int r,
                        input logic [31:0] data, input logic err,
                        input int s, input logic [3:0] s_tag);
    exp_t e;
    int   hs, ack_k;
    bit   done;
    e.to   = (r > int'(TO) - 1);
    e.data = (e.to || err) ? ERR : data;
    expq.push_back(e);
    logic_req  = 1'b1;
    logic_addr = addr;
    @(negedge clk);
    logic_addr = $urandom;
    chk("valid_latency", {31'b0, eng_req_valid}, 32'd1);
    hs = 0; done = 0; ack_k = -1;
    for (int k = 0; k < int'(TO) + 8 && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (logic_ack) begin
        done  = 1;
        ack_k = k;
        clear_inputs();
      end else begin
        if (eng_req_valid) begin
          chk("req_addr", eng_req_addr, addr);
          chk("req_tag", {28'b0, eng_req_tag}, {28'b0, m_tag});
        end
        eng_req_ready = (k >= h);
        if (eng_req_valid && eng_req_ready) hs++;
        eng_rsp_valid = (k == r) || (k == s);
        eng_rsp_tag   = (k == s) ? s_tag : m_tag;
        eng_rsp_data  = (k == s) ? ~data : data;
        eng_rsp_err   = (k == s) ? 1'b0 : err;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_wait_bound: got no ack, expected ack within %0d cycles", TO + 8);
      clear_inputs();
    end else begin
      chk("ack_cycle", ack_k, e.to ? TO : r + 1);
    end
    chk("handshakes", hs, 1);
    m_req++;
    m_tag++;
    if (e.to) m_to++;
    if (s >= 0) m_stale++;
    @(negedge clk);
    chk_counters("post");
  endtask

  // A response while idle must only bump stale_count.
  task automatic idle_stale();
    eng_rsp_valid = 1'b1;
    eng_rsp_tag   = 4'($urandom);
    eng_rsp_data  = $urandom;
    @(negedge clk);
    eng_rsp_valid = 1'b0;
    m_stale++;
    chk("idle_stale_count", {16'b0, stale_count}, m_stale);
  endtask

  // Reset asserted at cycle stop_k of a request: everything returns to zero, no ack.
  task automatic reset_mid(input int stop_k, input int h, input logic exp_valid);
    logic_req  = 1'b1;
    logic_addr = 32'h0000_0BAD;
    for (int k = 0; k <= stop_k; k++) begin
      @(negedge clk);
      eng_req_ready = (k >= h);
    end
    chk("pre_reset_valid", {31'b0, eng_req_valid}, {31'b0, exp_valid});
    rst = 1'b1;
    #1;
    chk("reset_valid_drop", {31'b0, eng_req_valid}, 32'd0);
    chk("reset_no_ack", {31'b0, logic_ack}, 32'd0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    m_req = 0; m_to = 0; m_stale = 0; m_tag = '0;
    repeat (3) @(negedge clk);
    chk_counters("after_reset");
  endtask

  initial begin
    int h, r, s;
    vectors = 0; miscompares = 0;
    m_req = 0; m_to = 0; m_stale = 0; m_tag = '0;
    rst = 1'b1;
    logic_addr = '0;
    clear_inputs();
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'b0, logic_ack}, 32'd0);
    chk("rst_valid", {31'b0, eng_req_valid}, 32'd0);
    chk("rst_data", logic_data, 32'd0);
    chk("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
    chk_counters("rst");
    rst = 1'b0;
    @(negedge clk);

    // Basic round trip, then a solver stall, a timeout, a stale late response and a race.
    do_req(32'h10, 0, 3, 32'hABCD1234, 1'b0, -1, 4'd0);
    do_req(32'h20, 10, 13, 32'h1111_2222, 1'b0, -1, 4'd0);
    do_req(32'h30, 0, 99, 32'h3333_4444, 1'b0, -1, 4'd0);
    do_req(32'h40, 0, 6, 32'h5555_6666, 1'b0, 3, m_tag - 4'd1);
    do_req(32'h50, 0, int'(TO) - 1, 32'h7777_8888, 1'b0, -1, 4'd0);
    do_req(32'h60, 2, int'(TO), 32'h9999_AAAA, 1'b0, -1, 4'd0);
    do_req(32'h70, 1, 4, 32'h1234_5678, 1'b1, -1, 4'd0);
    idle_stale();

    // Reset while stalled in issue, then while waiting; next request reuses tag 0.
    reset_mid(5, 8, 1'b1);
    reset_mid(4, 0, 1'b0);
    do_req(32'h80, 0, 2, 32'hCAFE_F00D, 1'b0, -1, 4'd0);

    for (int i = 0; i < 40; i++) begin
      h = $urandom_range(0, 6);
      r = h + 1 + $urandom_range(0, 12);
      s = -1;
      if ((r - h > 2) && ($urandom_range(0, 2) == 0)) begin
        s = $urandom_range(h + 1, r - 1);
        if (s > int'(TO) - 2) s = -1;
      end
      if ($urandom_range(0, 3) == 0) idle_stale();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_req($urandom, h, r, $urandom, 1'($urandom_range(0, 4) == 0), s,
             m_tag + 4'($urandom_range(1, 15)));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", expq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
